prng_arbiter: RTL and testbench

Round-robin arbiter sharing one 4-bit nibble PRNG between NREQ requesters. It drives the PRNG enable and synchronous reset and assembles consecutive 4-bit results into a WORD_W-bit word. It delivers each word to exactly one granted requester with a one-hot valid pulse. A timeout watchdog recovers a stalled PRNG by pulsing its reset.

---
 rtl/prng_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_prng_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_arbiter.sv
// prng_arbiter
// Round-robin arbiter that shares one 4-bit nibble PRNG between NREQ
// requesters. It builds WORD_W-bit words from consecutive PRNG nibbles, with
// the first nibble in the LSBs. Each finished word goes to the granted
// requester as a one-cycle, one-hot word_vld pulse. A watchdog recovers a
// stalled PRNG by pulsing its reset.
//
// Optional build macro: PRNG_STUCK_DET_EN
//   When defined, the block adds a sticky stuck_err output and a history
//   register holding the last delivered word. A word that repeats the
//   previous word, or is all-0 or all-1, sets stuck_err and resets the PRNG.
//
// Ports:
//   clk          clock, rising edge
//   res          asynchronous active-high reset
//   req          per-requester request levels
//   word_out     assembled word, meaningful while word_vld != 0
//   word_vld     one-hot delivery pulse to the grantee
//   busy         high whenever the FSM is not idle
//   timeout_err  sticky watchdog flag
//   stuck_err    sticky stuck-PRNG flag (PRNG_STUCK_DET_EN only)
//   prng_ena     PRNG enable
//   prng_res     PRNG synchronous reset (registered, high out of reset)
//   prng_dout    PRNG nibble
//   prng_done    PRNG done level
module prng_arbiter #(
  parameter int NREQ    = 4,
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  output logic [WORD_W-1:0] word_out,
  output logic [NREQ-1:0]   word_vld,
  output logic              busy,
  output logic              timeout_err,
`ifdef PRNG_STUCK_DET_EN
  output logic              stuck_err,
`endif
  output logic              prng_ena,
  output logic              prng_res,
  input  logic [3:0]        prng_dout,
  input  logic              prng_done
);

  localparam int NIB = WORD_W / 4;
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DELIVER
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     nib_cnt_q, nib_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [TW-1:0]     wdog_q, wdog_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              prng_res_q, prng_res_d;
`ifdef PRNG_STUCK_DET_EN
  logic              stuck_err_q, stuck_err_d;
  logic [WORD_W-1:0] last_word_q, last_word_d;
`endif

  logic              capture;
  logic              wdog_fire;
  logic              arb_found;
  logic [PW-1:0]     arb_idx;

  // Round-robin search: first requester after the pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!arb_found && req[PW'((int'(ptr_q) + i) % NREQ)]) begin
        arb_found = 1'b1;
        arb_idx   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  // Only a fresh rising edge of done counts, so a level left high after
  // delivery cannot be taken as a new nibble. A capture beats the watchdog
  // when both happen in the same cycle.
  assign capture   = (state_q == COLLECT) && prng_done && !done_q;
  assign wdog_fire = (state_q == COLLECT) && !capture &&
                     (wdog_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    nib_cnt_d     = nib_cnt_q;
    word_d        = word_q;
    wdog_d        = wdog_q;
    done_d        = prng_done;
    timeout_err_d = timeout_err_q;
    prng_res_d    = 1'b0;
`ifdef PRNG_STUCK_DET_EN
    stuck_err_d   = stuck_err_q;
    last_word_d   = last_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d   = arb_idx;
          ptr_d     = arb_idx;
          nib_cnt_d = '0;
          wdog_d    = '0;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (capture) begin
          word_d[int'(nib_cnt_q) * 4 +: 4] = prng_dout;
          wdog_d = '0;
          if (nib_cnt_q == CW'(NIB - 1)) begin
            state_d = DELIVER;
          end else begin
            nib_cnt_d = nib_cnt_q + CW'(1);
          end
        end else if (wdog_fire) begin
          // Put the pointer one behind the grantee so it wins again next time.
          timeout_err_d = 1'b1;
          prng_res_d    = 1'b1;
          word_d        = '0;
          nib_cnt_d     = '0;
          ptr_d         = (grant_q == '0) ? PW'(NREQ - 1) : grant_q - PW'(1);
          state_d       = IDLE;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      DELIVER: begin
        nib_cnt_d = '0;
        state_d   = IDLE;
`ifdef PRNG_STUCK_DET_EN
        last_word_d = word_q;
        if ((word_q == last_word_q) || (word_q == '0) || (word_q == '1)) begin
          stuck_err_d = 1'b1;
          prng_res_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q       <= IDLE;
      ptr_q         <= PW'(NREQ - 1);
      grant_q       <= '0;
      nib_cnt_q     <= '0;
      word_q        <= '0;
      wdog_q        <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      prng_res_q    <= 1'b1;
`ifdef PRNG_STUCK_DET_EN
      stuck_err_q   <= 1'b0;
      last_word_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      nib_cnt_q     <= nib_cnt_d;
      word_q        <= word_d;
      wdog_q        <= wdog_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      prng_res_q    <= prng_res_d;
`ifdef PRNG_STUCK_DET_EN
      stuck_err_q   <= stuck_err_d;
      last_word_q   <= last_word_d;
`endif
    end
  end

  assign word_out    = word_q;
  assign word_vld    = (state_q == DELIVER) ? (NREQ'(1) << grant_q) : '0;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;
  assign prng_ena    = (state_q == COLLECT) && !wdog_fire;
  assign prng_res    = prng_res_q;
`ifdef PRNG_STUCK_DET_EN
  assign stuck_err   = stuck_err_q;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed testbench for prng_arbiter. The bench itself acts as the PRNG stub,
// driving prng_done and prng_dout.
module tb_prng_arbiter;

  localparam int NREQ    = 4;
  localparam int WORD_W  = 16;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              res;
  logic [NREQ-1:0]   req;
  logic [WORD_W-1:0] word_out;
  logic [NREQ-1:0]   word_vld;
  logic              busy;
  logic              timeout_err;
`ifdef PRNG_STUCK_DET_EN
  logic              stuck_err;
`endif
  logic              prng_ena;
  logic              prng_res;
  logic [3:0]        prng_dout;
  logic              prng_done;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  prng_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .res        (res),
    .req        (req),
    .word_out   (word_out),
    .word_vld   (word_vld),
    .busy       (busy),
    .timeout_err(timeout_err),
`ifdef PRNG_STUCK_DET_EN
    .stuck_err  (stuck_err),
`endif
    .prng_ena   (prng_ena),
    .prng_res   (prng_res),
    .prng_dout  (prng_dout),
    .prng_done  (prng_done)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the requests and the PRNG stub in one step.
  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic d, input logic [3:0] n);
    req       = r;
    prng_done = d;
    prng_dout = n;
  endtask

  // One comparison: count it and report the observed and required values if they differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Feed the four nibbles of w as fresh done edges, LSB nibble first.
  // Returns in the cycle right after the last capture, which should be
  // DELIVER, with prng_done still high.
  task automatic collectWord(input logic [15:0] w, output logic [NREQ-1:0] vld,
                             output logic [15:0] wo);
    logic [15:0] tmp;
    tmp = w;
    for (int k = 0; k < 3; k++) begin
      prng_dout = tmp[4*k +: 4];
      prng_done = 1'b1;
      tick();
      prng_done = 1'b0;
      tick();
    end
    prng_dout = tmp[15:12];
    prng_done = 1'b1;
    tick();
    vld = word_vld;
    wo  = word_out;
  endtask

  // Collect a word and check the delivery pulse and the word value.
  task automatic deliverCheck(input string tag, input logic [15:0] w, input logic [NREQ-1:0] expVld);
    logic [NREQ-1:0] vld;
    logic [15:0]     wo;
    collectWord(w, vld, wo);
    checkOutput({tag, "_vld"}, 32'(vld), 32'(expVld));
    checkOutput({tag, "_word"}, 32'(wo), 32'(w));
  endtask

  initial begin
    res = 1'b1;
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    checkOutput("rst_word_out", 32'(word_out), 32'h0);
    checkOutput("rst_word_vld", 32'(word_vld), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("rst_prng_ena", 32'(prng_ena), 32'h0);
    checkOutput("rst_prng_res", 32'(prng_res), 32'h1);
    res = 1'b0;
    tick();
    checkOutput("rel_prng_res", 32'(prng_res), 32'h0);
    checkOutput("rel_busy", 32'(busy), 32'h0);

    // Single requester.
    applyStimulus(4'b0001, 1'b0, 4'h0);
    tick();
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_ena", 32'(prng_ena), 32'h1);
    deliverCheck("single", 16'h4321, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    checkOutput("single_vld_gone", 32'(word_vld), 32'h0);
    checkOutput("single_idle_busy", 32'(busy), 32'h0);

    // Fresh reset so the round-robin pointer starts at NREQ-1.
    res = 1'b1;
    tick();
    res = 1'b0;
    tick();

    // Round-robin with all four requesting.
    applyStimulus(4'b1111, 1'b0, 4'h0);
    tick();
    deliverCheck("rr0", 16'h1357, 4'b0001);
    applyStimulus(4'b1110, 1'b0, 4'h0);
    tick();
    tick();
    deliverCheck("rr1", 16'h2468, 4'b0010);
    applyStimulus(4'b1100, 1'b0, 4'h0);
    tick();
    tick();
    deliverCheck("rr2", 16'h9753, 4'b0100);
    applyStimulus(4'b1000, 1'b0, 4'h0);
    tick();
    tick();
    deliverCheck("rr3", 16'h8642, 4'b1000);
    applyStimulus(4'b0011, 1'b0, 4'h0);
    tick();
    tick();
    deliverCheck("rr4", 16'hC0DE, 4'b0001);
    applyStimulus(4'b0010, 1'b0, 4'h0);
    tick();
    tick();
    deliverCheck("rr5", 16'h7E57, 4'b0010);

    // prng_done held high across DELIVER/IDLE into COLLECT: no recapture.
    applyStimulus(4'b0001, 1'b1, 4'hF);
    tick();
    tick();
    tick();
    tick();
    checkOutput("stuckdone_ena", 32'(prng_ena), 32'h1);
    checkOutput("stuckdone_vld", 32'(word_vld), 32'h0);
    applyStimulus(4'b0001, 1'b0, 4'h0);
    tick();
    deliverCheck("stuckdone", 16'h5A3C, 4'b0001);

    // Watchdog: no done edges for TIMEOUT COLLECT cycles.
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    applyStimulus(4'b0100, 1'b0, 4'h0);
    tick();
    repeat (TIMEOUT - 1) tick();
    checkOutput("wd_last_busy", 32'(busy), 32'h1);
    checkOutput("wd_last_err", 32'(timeout_err), 32'h0);
    checkOutput("wd_last_res", 32'(prng_res), 32'h0);
    tick();
    checkOutput("wd_fire_err", 32'(timeout_err), 32'h1);
    checkOutput("wd_fire_res", 32'(prng_res), 32'h1);
    checkOutput("wd_fire_vld", 32'(word_vld), 32'h0);
    checkOutput("wd_fire_busy", 32'(busy), 32'h0);
    applyStimulus(4'b0110, 1'b0, 4'h0);
    tick();
    checkOutput("wd_after_res", 32'(prng_res), 32'h0);
    checkOutput("wd_after_busy", 32'(busy), 32'h1);
    deliverCheck("wd_regrant", 16'hBEEF, 4'b0100);

    // A capture in the cycle the watchdog would fire wins.
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    checkOutput("wd_sticky", 32'(timeout_err), 32'h1);
    applyStimulus(4'b0010, 1'b0, 4'h0);
    tick();
    repeat (TIMEOUT - 1) tick();
    deliverCheck("wd_tie", 16'hA987, 4'b0010);

    // Async reset in the middle of COLLECT after two nibbles.
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    applyStimulus(4'b0001, 1'b0, 4'h0);
    tick();
    for (int k = 1; k <= 2; k++) begin
      prng_dout = 4'(k);
      prng_done = 1'b1;
      tick();
      prng_done = 1'b0;
      tick();
    end
    res = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_ena", 32'(prng_ena), 32'h0);
    checkOutput("midrst_prng_res", 32'(prng_res), 32'h1);
    checkOutput("midrst_word", 32'(word_out), 32'h0);
    checkOutput("midrst_vld", 32'(word_vld), 32'h0);
    checkOutput("midrst_err", 32'(timeout_err), 32'h0);
    tick();
    res = 1'b0;
    tick();
    checkOutput("midrst_rel_res", 32'(prng_res), 32'h0);
    checkOutput("midrst_rel_busy", 32'(busy), 32'h1);
    deliverCheck("midrst", 16'h2468, 4'b0001);

    // Two consecutive identical words.
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    applyStimulus(4'b0010, 1'b0, 4'h0);
    tick();
    deliverCheck("rep1", 16'hABCD, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
    checkOutput("rep1_res", 32'(prng_res), 32'h0);
    applyStimulus(4'b0010, 1'b0, 4'h0);
    tick();
    deliverCheck("rep2", 16'hABCD, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 4'h0);
    tick();
`ifdef PRNG_STUCK_DET_EN
    checkOutput("rep2_res", 32'(prng_res), 32'h1);
    checkOutput("rep2_stuck", 32'(stuck_err), 32'h1);
`else
    checkOutput("rep2_res", 32'(prng_res), 32'h0);
`endif
    tick();
    checkOutput("rep2_res_end", 32'(prng_res), 32'h0);
`ifdef PRNG_STUCK_DET_EN
    checkOutput("rep2_stuck_sticky", 32'(stuck_err), 32'h1);
`endif

    $display("[TB] directed sequence complete, %0d failing", failCount);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
